// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: scan-code set 2
// prefixes, the list of keyboard status bytes that carry no key event,
// the decoder state encoding and the frame bit-counter width.
package ps2_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

   // Keyboard status/response bytes that must never become key events
   localparam int PS2_NUM_IGNORED = 6;
   localparam logic [PS2_NUM_IGNORED-1:0][7:0] PS2_IGNORED_CODES =
      {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

   // Frame bit counter runs 0..10 (start, 8 data, parity, stop)
   localparam int PS2_BIT_CNT_W = 4;
   localparam logic [PS2_BIT_CNT_W-1:0] PS2_STOP_BIT_IDX = 4'd10;

   typedef enum logic [1:0] {
      DEC_IDLE    = 2'd0,
      DEC_EXT     = 2'd1,
      DEC_BRK     = 2'd2,
      DEC_EXT_BRK = 2'd3
   } ps2_dec_state_e;

   // True when the byte is a status/response code with no key meaning
   function automatic logic ps2_is_ignored(input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < PS2_NUM_IGNORED; i++) begin
         if (code == PS2_IGNORED_CODES[i]) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/ps2_frame_receiver.sv
// PS/2 frame receiver: synchronises both lines, glitch-filters the keyboard
// clock, shifts in 11-bit frames on filtered falling edges, checks start,
// odd parity and stop, and aborts a frame when the clock stalls.
module ps2_frame_receiver
   import ps2_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 2000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_data_o,
   output logic       frame_error_o,
   output logic       timeout_o
);

   localparam int TIMEOUT_CYCLES = (CLK_HZ / 1000000) * TIMEOUT_US;
   localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam int FLT_W          = 5;
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

   logic [1:0]               clk_sync_q;
   logic [1:0]               dat_sync_q;
   logic                     clk_s;
   logic                     dat_s;

   logic                     flt_val_q, flt_val_d;
   logic                     flt_prev_q;
   logic [FLT_W-1:0]         flt_cnt_q, flt_cnt_d;
   logic                     fall_edge;

   logic [PS2_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [10:0]              shift_q, shift_d;
   logic                     done_q, done_d;
   logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
   logic                     to_fire;
   logic                     frame_ok;

   logic                     byte_valid_q;
   logic [7:0]               byte_data_q;
   logic                     frame_error_q;
   logic                     timeout_q;

   assign clk_s = clk_sync_q[1];
   assign dat_s = dat_sync_q[1];

   // Two-flop synchronisers for the asynchronous keyboard lines (idle high)
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
         dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      end
   end

   // Glitch filter: accept a new clock level after FILTER_LEN samples in a row
   always_comb begin
      flt_val_d = flt_val_q;
      flt_cnt_d = '0;
      if (clk_s != flt_val_q) begin
         if (flt_cnt_q == FLT_LAST) begin
            flt_val_d = clk_s;
         end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
         end
      end
   end

   // Filter state and previous filtered level for edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flt_val_q  <= 1'b1;
         flt_prev_q <= 1'b1;
         flt_cnt_q  <= '0;
      end else begin
         flt_val_q  <= flt_val_d;
         flt_prev_q <= flt_val_q;
         flt_cnt_q  <= flt_cnt_d;
      end
   end

   assign fall_edge = flt_prev_q & ~flt_val_q;

   // Bit counter, shift register and inter-edge timeout
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      done_d    = 1'b0;
      to_cnt_d  = to_cnt_q;
      to_fire   = 1'b0;
      if (fall_edge) begin
         to_cnt_d = '0;
         if (bit_cnt_q == '0) begin
            // A high start bit is line noise: stay waiting for a real start
            if (!dat_s) begin
               shift_d   = {dat_s, shift_q[10:1]};
               bit_cnt_d = PS2_BIT_CNT_W'(1);
            end
         end else begin
            shift_d = {dat_s, shift_q[10:1]};
            if (bit_cnt_q == PS2_STOP_BIT_IDX) begin
               bit_cnt_d = '0;
               done_d    = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
      end else if (bit_cnt_q != '0) begin
         if (to_cnt_q == TO_LAST) begin
            to_cnt_d  = '0;
            bit_cnt_d = '0;
            to_fire   = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   // Frame receiver state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bit_cnt_q <= '0;
         shift_q   <= '0;
         done_q    <= 1'b0;
         to_cnt_q  <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         done_q    <= done_d;
         to_cnt_q  <= to_cnt_d;
      end
   end

   // shift_q[0] = start, [8:1] = data LSB first, [9] = parity, [10] = stop
   assign frame_ok = ~shift_q[0] & (^shift_q[9:1]) & shift_q[10];

   // Frame verdict one cycle after the stop bit: good byte or error pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         byte_valid_q  <= 1'b0;
         byte_data_q   <= '0;
         frame_error_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         byte_valid_q  <= done_q & frame_ok;
         frame_error_q <= (done_q & ~frame_ok) | to_fire;
         timeout_q     <= to_fire;
         if (done_q) begin
            byte_data_q <= shift_q[8:1];
         end
      end
   end

   assign byte_valid_o  = byte_valid_q;
   assign byte_data_o   = byte_data_q;
   assign frame_error_o = frame_error_q;
   assign timeout_o     = timeout_q;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 scan-code set 2 receiver: turns raw keyboard frames into one-cycle
// make/break events with the scan code and E0-extension flag.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses typematic repeat makes
// of the key that is currently held down.
module ps2_scancode_receiver
   import ps2_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 2000
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic       KEY_MAKE,
   output logic       KEY_BREAK,
   output logic [7:0] KEY_DATA,
   output logic       KEY_EXTENDED,
   output logic       FRAME_ERROR
);

   logic           byte_valid;
   logic [7:0]     byte_data;
   logic           frame_error;
   logic           rx_timeout;

   logic           is_ext;
   logic           is_brk;
   logic           is_ign;
   logic           emit_make;
   logic           emit_break;
   logic           emit_ext;
   logic           repeat_hit;
   logic           make_fire;

   ps2_dec_state_e state_q;
   logic           key_make_q;
   logic           key_break_q;
   logic [7:0]     key_data_q;
   logic           key_ext_q;

   ps2_frame_receiver #(
      .CLK_HZ     (CLK_HZ),
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_US (TIMEOUT_US)
   ) u_frame_rx (
      .clk_i         (CLK),
      .rst_ni        (RESET_N),
      .ps2_clk_i     (PS2_CLK),
      .ps2_dat_i     (PS2_DAT),
      .byte_valid_o  (byte_valid),
      .byte_data_o   (byte_data),
      .frame_error_o (frame_error),
      .timeout_o     (rx_timeout)
   );

   assign is_ext = (byte_data == PS2_PREFIX_EXT);
   assign is_brk = (byte_data == PS2_PREFIX_BRK);
   assign is_ign = ps2_is_ignored(byte_data);

   // Classify a received non-prefix byte as make/break given the prefix state
   always_comb begin
      emit_make  = 1'b0;
      emit_break = 1'b0;
      emit_ext   = 1'b0;
      if (byte_valid && !is_ext && !is_brk) begin
         case (state_q)
            DEC_IDLE: begin
               emit_make = ~is_ign;
            end
            DEC_EXT: begin
               emit_make = 1'b1;
               emit_ext  = 1'b1;
            end
            DEC_BRK: begin
               emit_break = 1'b1;
            end
            DEC_EXT_BRK: begin
               emit_break = 1'b1;
               emit_ext   = 1'b1;
            end
            default: begin
               emit_make = 1'b0;
            end
         endcase
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic       tm_valid_q;
   logic       tm_ext_q;
   logic [7:0] tm_code_q;

   assign repeat_hit = tm_valid_q && (tm_ext_q == emit_ext) && (tm_code_q == byte_data);

   // Held-key tracker: remembers the last make until its break or an error
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         tm_valid_q <= 1'b0;
         tm_ext_q   <= 1'b0;
         tm_code_q  <= '0;
      end else if (frame_error) begin
         tm_valid_q <= 1'b0;
      end else if (make_fire) begin
         tm_valid_q <= 1'b1;
         tm_ext_q   <= emit_ext;
         tm_code_q  <= byte_data;
      end else if (emit_break && repeat_hit) begin
         tm_valid_q <= 1'b0;
      end
   end
`else
   assign repeat_hit = 1'b0;
`endif

   assign make_fire = emit_make & ~repeat_hit;

   // Prefix-decoding FSM with registered event outputs
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= DEC_IDLE;
         key_make_q  <= 1'b0;
         key_break_q <= 1'b0;
         key_data_q  <= '0;
         key_ext_q   <= 1'b0;
      end else begin
         key_make_q  <= make_fire;
         key_break_q <= emit_break;
         if (make_fire || emit_break) begin
            key_data_q <= byte_data;
            key_ext_q  <= emit_ext;
         end
         if (rx_timeout) begin
            state_q <= DEC_IDLE;
         end else if (byte_valid) begin
            case (state_q)
               DEC_IDLE: begin
                  if (is_ext)      state_q <= DEC_EXT;
                  else if (is_brk) state_q <= DEC_BRK;
                  else             state_q <= DEC_IDLE;
               end
               DEC_EXT: begin
                  if (is_ext)      state_q <= DEC_EXT;
                  else if (is_brk) state_q <= DEC_EXT_BRK;
                  else             state_q <= DEC_IDLE;
               end
               DEC_BRK: begin
                  if (is_ext)      state_q <= DEC_EXT;
                  else if (is_brk) state_q <= DEC_BRK;
                  else             state_q <= DEC_IDLE;
               end
               DEC_EXT_BRK: begin
                  if (is_ext)      state_q <= DEC_EXT;
                  else if (is_brk) state_q <= DEC_EXT_BRK;
                  else             state_q <= DEC_IDLE;
               end
               default: begin
                  state_q <= DEC_IDLE;
               end
            endcase
         end
      end
   end

   assign KEY_MAKE     = key_make_q;
   assign KEY_BREAK    = key_break_q;
   assign KEY_DATA     = key_data_q;
   assign KEY_EXTENDED = key_ext_q;
   assign FRAME_ERROR  = frame_error;

endmodule
